// File: rtl/fan_duty_ramp.sv
// Fan duty generator: buttons select a speed level and breeze mode, and the
// 9-bit PWM duty slews toward the resulting target one step per prescaler tick.
module fan_duty_ramp #(
    parameter int RAMP_DIV    = 195_312,
    parameter int DUTY_L1     = 170,
    parameter int DUTY_L2     = 340,
    parameter int DUTY_L3     = 511,
    parameter int BREEZE_HOLD = 300_000_000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       btn_speed,
    input  logic       btn_off,
    input  logic       btn_breeze,
    output logic [8:0] duty,
    output logic [1:0] level,
    output logic       breeze_on,
    output logic       busy
);
    localparam int PW = $clog2(RAMP_DIV + 1);
    localparam int CW = $clog2(BREEZE_HOLD + 1);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD, DWELL} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   prescaler;
    logic [CW-1:0]   dwell_cnt;
    logic            phase_high;
    logic [1:0]      level_prev;
    logic [8:0]      level_target, target;
    logic            tick, breeze_act, breeze_dwell, dwell_clr, dwell_done;

    assign tick         = (prescaler == PW'(RAMP_DIV - 1));
    assign breeze_act   = !btn_off && !btn_speed && btn_breeze && (level != 2'd0);
    assign breeze_dwell = breeze_on && (level >= 2'd2);

    always_comb begin
        case (level)
            2'd0:    level_target = 9'd0;
            2'd1:    level_target = 9'(DUTY_L1);
            2'd2:    level_target = 9'(DUTY_L2);
            default: level_target = 9'(DUTY_L3);
        endcase
        target = (breeze_dwell && !phase_high) ? 9'(DUTY_L1) : level_target;
    end

    assign busy = (duty != target);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            level      <= 2'd0;
            level_prev <= 2'd0;
            breeze_on  <= 1'b0;
            phase_high <= 1'b1;
        end else begin
            level_prev <= level;
            if (btn_off) begin
                level     <= 2'd0;
                breeze_on <= 1'b0;
            end else if (btn_speed) begin
                level <= level + 2'd1;
                if (level == 2'd3)
                    breeze_on <= 1'b0;
            end else if (breeze_act) begin
                breeze_on <= !breeze_on;
            end
            // A breeze toggle restarts the cycle on the high side even if a dwell expires now
            if (breeze_act)
                phase_high <= 1'b1;
            else if (dwell_done)
                phase_high <= !phase_high;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            prescaler <= '0;
            duty      <= 9'd0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick) begin
                if (duty < target)
                    duty <= duty + 9'd1;
                else if (duty > target)
                    duty <= duty - 9'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state     <= IDLE;
            dwell_cnt <= '0;
        end else begin
            state <= state_n;
            if (dwell_clr || dwell_done)
                dwell_cnt <= '0;
            else if (state == DWELL)
                dwell_cnt <= dwell_cnt + CW'(1);
        end
    end

    always_comb begin
        state_n    = state;
        dwell_clr  = 1'b0;
        dwell_done = 1'b0;
        case (state)
            IDLE: begin
                if (target != duty)
                    state_n = RAMP;
            end
            RAMP: begin
                if (duty == target) begin
                    if (breeze_dwell) begin
                        state_n   = DWELL;
                        dwell_clr = 1'b1;
                    end else if (level == 2'd0 && duty == 9'd0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (target != duty) begin
                    state_n = RAMP;
                end else if (breeze_dwell) begin
                    state_n   = DWELL;
                    dwell_clr = 1'b1;
                end
            end
            default: begin
                // Leaving breeze or changing level aborts the dwell without flipping phase
                if (!breeze_dwell || level != level_prev) begin
                    state_n = (target != duty) ? RAMP : HOLD;
                end else if (dwell_cnt == CW'(BREEZE_HOLD - 1)) begin
                    dwell_done = 1'b1;
                    state_n    = RAMP;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_fan_duty_ramp.sv
// Directed bench for fan_duty_ramp: button vector table plus ramp, breeze and reset sequences.
module tb_fan_duty_ramp;
    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       btn_speed = 1'b0;
    logic       btn_off = 1'b0;
    logic       btn_breeze = 1'b0;
    logic [8:0] duty;
    logic [1:0] level;
    logic       breeze_on;
    logic       busy;

    int total = 0;
    int passed = 0;

    fan_duty_ramp #(
        .RAMP_DIV(4),
        .BREEZE_HOLD(20)
    ) dut (
        .clk(clk),
        .reset_p(reset_p),
        .btn_speed(btn_speed),
        .btn_off(btn_off),
        .btn_breeze(btn_breeze),
        .duty(duty),
        .level(level),
        .breeze_on(breeze_on),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       off;
        logic       spd;
        logic       brz;
        logic [1:0] lvl;
        logic       brz_on;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic pulse(input logic o, input logic s, input logic b);
        @(negedge clk);
        btn_off = o; btn_speed = s; btn_breeze = b;
        @(negedge clk);
        btn_off = 1'b0; btn_speed = 1'b0; btn_breeze = 1'b0;
    endtask

    task automatic do_reset();
        reset_p = 1'b1;
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
    endtask

    // Waits for duty to hit val; every change must be a single step in dir, 4 clks apart.
    task automatic wait_duty(input string name, input int val, input int dir, input int bound);
        int prev, n, bad, bad_gap, last_chg;
        prev = int'(duty); n = 0; bad = 0; bad_gap = 0; last_chg = -1;
        while (int'(duty) != val && n < bound) begin
            @(negedge clk);
            n++;
            if (int'(duty) != prev) begin
                if (int'(duty) - prev != dir) bad++;
                if (last_chg >= 0 && n - last_chg != 4) bad_gap++;
                last_chg = n;
                prev = int'(duty);
            end
        end
        chk({name, " reached"}, int'(duty), val);
        chk({name, " step"}, bad, 0);
        chk({name, " gap"}, bad_gap, 0);
    endtask

    task automatic hold_len(input int val, output int n);
        n = 0;
        while (int'(duty) == val && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0};

        @(negedge clk);
        chk("reset duty", int'(duty), 0);
        chk("reset level", int'(level), 0);
        chk("reset breeze", int'(breeze_on), 0);
        chk("reset busy", int'(busy), 0);
        reset_p = 1'b0;

        for (int i = 0; i < 14; i++) begin
            pulse(vecs[i].off, vecs[i].spd, vecs[i].brz);
            chk($sformatf("vec%0d level", i), int'(level), int'(vecs[i].lvl));
            chk($sformatf("vec%0d breeze", i), int'(breeze_on), int'(vecs[i].brz_on));
        end

        // Ramp up to level 1
        do_reset();
        pulse(1'b0, 1'b1, 1'b0);
        chk("l1 level", int'(level), 1);
        chk("l1 busy", int'(busy), 1);
        wait_duty("l1 up", 170, 1, 1000);
        chk("l1 arrived busy", int'(busy), 0);
        repeat (10) @(negedge clk);
        chk("l1 steady", int'(duty), 170);

        // Up to level 3, then wrap to 0 and ramp down
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("l3 level", int'(level), 3);
        wait_duty("l3 up", 511, 1, 2000);
        chk("l3 arrived busy", int'(busy), 0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("wrap level", int'(level), 0);
        chk("wrap breeze", int'(breeze_on), 0);
        wait_duty("wrap down", 0, -1, 3000);
        chk("wrap busy", int'(busy), 0);
        repeat (10) @(negedge clk);
        chk("wrap floor", int'(duty), 0);

        // Breeze cycling at level 2
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_duty("l2 up", 340, 1, 2000);
        repeat (5) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        chk("breeze on", int'(breeze_on), 1);
        hold_len(340, n);
        chk_range("breeze dwell hi", n, 21, 26);
        wait_duty("breeze down", 170, -1, 1000);
        hold_len(170, n);
        chk_range("breeze dwell lo", n, 21, 26);
        wait_duty("breeze up", 340, 1, 1000);
        hold_len(340, n);
        chk_range("breeze dwell hi2", n, 21, 26);
        chk("breeze still on", int'(breeze_on), 1);

        // btn_off mid-ramp reverses without a jump
        do_reset();
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_duty("l3 to 300", 300, 1, 2000);
        pulse(1'b1, 1'b0, 1'b0);
        chk("off level", int'(level), 0);
        chk("off breeze", int'(breeze_on), 0);
        chk_range("off no jump", int'(duty), 300, 301);
        wait_duty("off down", 0, -1, 2000);

        // Asynchronous reset mid-ramp
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_duty("l3 to 250", 250, 1, 2000);
        @(posedge clk);
        #2 reset_p = 1'b1;
        #1;
        chk("async duty", int'(duty), 0);
        chk("async level", int'(level), 0);
        chk("async breeze", int'(breeze_on), 0);
        chk("async busy", int'(busy), 0);
        @(negedge clk);
        reset_p = 1'b0;
        pulse(1'b0, 1'b1, 1'b0);
        chk("resume level", int'(level), 1);
        wait_duty("resume up", 5, 1, 200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fan_duty_ramp.md
Name: fan_duty_ramp

Overview:
Upstream duty generator for the fan's 512-step PWM stage. Converts user button pulses into a speed level (0..3) and an optional "breeze" (natural-wind) mode. It drives a 9-bit duty word that moves toward its target one step at a time, at a programmable rate, so motor speed never jumps. The duty output connects directly to the PWM stage's duty input. The level, breeze and busy outputs go to the FND/LED display logic.

Parameters:
RAMP_DIV, 195_312, clk cycles per duty step (about 1 s for a full 0..511 sweep at 100 MHz); must be >= 1
DUTY_L1, 170, target duty for level 1
DUTY_L2, 340, target duty for level 2
DUTY_L3, 511, target duty for level 3
BREEZE_HOLD, 300_000_000, clk cycles of dwell at each breeze extreme; must be >= 1

Ports:
clk  in  1  system clock
reset_p  in  1  asynchronous reset, active-high
btn_speed  in  1  single-cycle pulse; advance level 0->1->2->3->0
btn_off  in  1  single-cycle pulse; force level 0
btn_breeze  in  1  single-cycle pulse; toggle breeze mode
duty  out  9  current duty to the PWM stage
level  out  2  current speed level
breeze_on  out  1  breeze mode active
busy  out  1  1 while duty != current target

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-ramp or mid-dwell):
  - duty=0, level=0, breeze_on=0, busy=0.
  - Prescaler=0, dwell counter=0, breeze phase=HIGH, state=IDLE.
- Button priority when pulses coincide in the same cycle: btn_off > btn_speed > btn_breeze. Only the highest-priority pulse acts; the others are ignored.
- btn_off: level<=0 and breeze_on<=0 on the next edge.
- btn_speed: level<=level+1, wrapping 3->0. When the wrap to 0 occurs, breeze_on is also cleared.
- btn_breeze:
  - At level 0: ignored.
  - Otherwise: breeze_on toggles. Phase resets to HIGH on both enable and disable.
- Level target: 0, DUTY_L1, DUTY_L2 or DUTY_L3 for levels 0..3.
- Effective target:
  - Equals the level target, except when breeze_on=1, level>=2 and phase=LOW. In that case the target is DUTY_L1.
  - At level 1, breeze has no effect; the target stays at DUTY_L1.
- Target changes are combinational from the registered level, breeze_on and phase.
- Prescaler:
  - Free-running 0..RAMP_DIV-1. tick=1 for one cycle at the wrap to 0.
  - Not cleared on level or target changes.
- On tick, duty steps by exactly 1 toward the target: +1 if below, -1 if above, unchanged if equal.
- Duty never overshoots the target and never leaves the range 0..511; no wrap-around.
- busy = (duty != target), combinational.
- A target change mid-ramp redirects the ramp from the present duty. There is no jump, and direction reverses on the next tick if needed.
- State machine, registered:
  - IDLE: level=0 and duty=0. Go to RAMP when target != duty.
  - RAMP: duty != target. When duty reaches target:
    - breeze_on and level>=2: go to DWELL and clear the dwell counter.
    - level=0 and duty=0: go to IDLE.
    - otherwise: go to HOLD.
  - HOLD: duty == target. Go to RAMP on any target change, or to DWELL if breeze is enabled at level>=2.
  - DWELL:
    - The dwell counter increments every clk.
    - At BREEZE_HOLD-1: flip phase, clear the counter, go to RAMP.
    - If breeze_on drops or level changes: go to RAMP if the new target != duty, else HOLD.
- Output latency: level and breeze_on update 1 cycle after the button pulse. duty updates 1 cycle after a qualifying tick.

Test Plan:
(Use RAMP_DIV=4, BREEZE_HOLD=20, default duty levels.)
1. Reset, then one btn_speed pulse -> level=1 next cycle; busy=1; duty rises 0->170 at 1 step per 4 clks (about 680 clks); busy=0 on arrival; state HOLD.
2. Two more btn_speed pulses (level 3), then a 4th pulse -> level wraps to 0; duty ramps down to 0 with no underflow; state IDLE, busy=0.
3. At level 2 with duty steady at 340, pulse btn_breeze -> breeze_on=1; after 20-clk dwell, duty ramps down to 170, dwells 20 clks, ramps back up to 340; cycle repeats.
4. Mid-ramp at level 3 with duty=300, pulse btn_off -> level=0, breeze_on=0; duty reverses and descends from 300 (no jump) to 0.
5. btn_off, btn_speed and btn_breeze asserted in the same cycle at level 2 -> only btn_off acts: level=0, breeze_on=0.
6. Assert reset_p asynchronously mid-ramp (duty=250) -> duty, level, breeze_on and busy are all 0 immediately, before the next clk edge; normal operation resumes after release.
